// File: rtl/led_shifter_pkg.sv
// Shared types for the LED shifter family: shift direction and shift mode encodings.
package led_shifter_pkg;

  typedef enum logic {DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1} dir_e;
  typedef enum logic {MODE_FILL = 1'b0, MODE_ROTATE = 1'b1} mode_e;

endpackage

// File: rtl/led_shifter_multi_tick_divider.sv
// tick_divider: free-running 0..DIV-1 counter that pulses tick_o on its last count.
// Cleared while disabled or on clr_i; reusable by any timer-driven block.
module tick_divider #(
  parameter int DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_reg;
  logic          at_last;

  assign at_last = (cnt_reg == LAST);
  // Tick is combinational so the shift lands on the same edge the count wraps.
  assign tick_o  = en_i & ~clr_i & at_last;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i || !en_i) begin
      cnt_reg <= '0;
    end else if (at_last) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

endmodule

// File: rtl/led_shifter_multi.sv
// Parametrised LED shift register with fill/rotate, saturating shift count and full flags.
// Define LED_SHIFTER_MULTI_AUTO_EN to build the run_i-driven auto-shift timer.
module led_shifter_multi
  import led_shifter_pkg::*;
#(
  parameter int   WIDTH    = 16,
  parameter logic FILL_VAL = 1'b1,
  parameter int   CNT_W    = 8,
  parameter int   TICK_DIV = 50_000_000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             shift_i,
  input  logic             dir_i,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] switches_i,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic             off_i,
  input  logic             run_i,
  output logic [WIDTH-1:0] leds_o,
  output logic             full_o,
  output logic             full_pulse_o,
  output logic [CNT_W-1:0] shift_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] q_reg, q_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             full_pulse_reg;
  logic             auto_tick;
  logic             do_shift;
  logic             shift_in;
  dir_e             dir;
  mode_e            mode;

`ifdef LED_SHIFTER_MULTI_AUTO_EN
  tick_divider #(
    .DIV(TICK_DIV)
  ) u_tick (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (run_i),
    .clr_i  (clear_i | load_i),
    .tick_o (auto_tick)
  );
`else
  localparam int unused_tick_div = TICK_DIV;
  logic unused_run;
  assign unused_run = run_i;
  assign auto_tick  = 1'b0;
`endif

  assign dir      = dir_e'(dir_i);
  assign mode     = mode_e'(mode_i);
  assign do_shift = shift_i | auto_tick;

  // Rotate feeds back the bit falling off the far end; fill injects FILL_VAL.
  always_comb begin
    shift_in = FILL_VAL;
    if (mode == MODE_ROTATE) begin
      shift_in = (dir == DIR_LEFT) ? q_reg[WIDTH-1] : q_reg[0];
    end
  end

  always_comb begin
    q_next   = q_reg;
    cnt_next = cnt_reg;
    if (clear_i) begin
      q_next   = '0;
      cnt_next = '0;
    end else if (load_i) begin
      q_next   = switches_i;
      cnt_next = '0;
    end else if (do_shift) begin
      q_next = (dir == DIR_LEFT) ? {q_reg[WIDTH-2:0], shift_in}
                                 : {shift_in, q_reg[WIDTH-1:1]};
      if (cnt_reg != CNT_MAX) begin
        cnt_next = cnt_reg + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_reg          <= '0;
      cnt_reg        <= '0;
      full_pulse_reg <= 1'b0;
    end else begin
      q_reg          <= q_next;
      cnt_reg        <= cnt_next;
      full_pulse_reg <= (&q_next) & ~(&q_reg);
    end
  end

  assign leds_o       = off_i ? '0 : q_reg;
  assign full_o       = &q_reg;
  assign full_pulse_o = full_pulse_reg;
  assign shift_cnt_o  = cnt_reg;

endmodule
